bp_update_queue: RTL

Buffers branch-resolution updates between commit and the branch predictor and sequences them onto the predictor's two in-order update ports. Commit delivers up to two resolved branches per cycle; the predictor ignores updates in any cycle its `flush` is high, so committed updates must be held rather than lost. The block is a 2-in/2-out FIFO with a flush-aware drain and program-order guarantees. It also keeps update and mispredict statistics. It sits between the commit stage and the predictor's `update0_*` / `update1_*` ports.

---
 rtl/bp_update_queue_if.sv | 69 ++++++
 rtl/bp_update_queue.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bp_update_queue_if.sv
// Commit-to-predictor update bus: two commit slots in, in_ready back, two update slots out.
// The queue takes the slave side; commit and predictor together act as master.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 16
`endif

interface bp_update_queue_if #(
  parameter int unsigned ADDR_W   = `INST_ADDR_WIDTH,
  parameter int unsigned GHR_BITS = `BP_GHR_BITS
);
  logic                in0_valid;
  logic [ADDR_W-1:0]   in0_pc;
  logic                in0_taken;
  logic [ADDR_W-1:0]   in0_target;
  logic [GHR_BITS-1:0] in0_hist;
  logic                in0_is_call;
  logic                in0_is_return;
  logic                in0_mispredict;

  logic                in1_valid;
  logic [ADDR_W-1:0]   in1_pc;
  logic                in1_taken;
  logic [ADDR_W-1:0]   in1_target;
  logic [GHR_BITS-1:0] in1_hist;
  logic                in1_is_call;
  logic                in1_is_return;
  logic                in1_mispredict;

  logic                in_ready;

  logic                out0_valid;
  logic [ADDR_W-1:0]   out0_pc;
  logic                out0_taken;
  logic [ADDR_W-1:0]   out0_target;
  logic [GHR_BITS-1:0] out0_hist;
  logic                out0_is_call;
  logic                out0_is_return;

  logic                out1_valid;
  logic [ADDR_W-1:0]   out1_pc;
  logic                out1_taken;
  logic [ADDR_W-1:0]   out1_target;
  logic [GHR_BITS-1:0] out1_hist;
  logic                out1_is_call;
  logic                out1_is_return;

  modport master (
    output in0_valid, in0_pc, in0_taken, in0_target, in0_hist, in0_is_call, in0_is_return,
           in0_mispredict,
    output in1_valid, in1_pc, in1_taken, in1_target, in1_hist, in1_is_call, in1_is_return,
           in1_mispredict,
    input  in_ready,
    input  out0_valid, out0_pc, out0_taken, out0_target, out0_hist, out0_is_call, out0_is_return,
    input  out1_valid, out1_pc, out1_taken, out1_target, out1_hist, out1_is_call, out1_is_return
  );

  modport slave (
    input  in0_valid, in0_pc, in0_taken, in0_target, in0_hist, in0_is_call, in0_is_return,
           in0_mispredict,
    input  in1_valid, in1_pc, in1_taken, in1_target, in1_hist, in1_is_call, in1_is_return,
           in1_mispredict,
    output in_ready,
    output out0_valid, out0_pc, out0_taken, out0_target, out0_hist, out0_is_call, out0_is_return,
    output out1_valid, out1_pc, out1_taken, out1_target, out1_hist, out1_is_call, out1_is_return
  );
endinterface

// File: rtl/bp_update_queue.sv
// 2-in/2-out FIFO holding resolved-branch updates until the predictor can take them.
// Outputs are suppressed (and nothing pops) while flush is high; contents are kept.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 16
`endif

module bp_update_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = `INST_ADDR_WIDTH,
  parameter int unsigned GHR_BITS = `BP_GHR_BITS,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  bp_update_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         upd_count_o,
  output logic [CNT_W-1:0]         mispred_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0] ReadyMax = (PtrW + 1)'(DEPTH - 2);

  typedef struct packed {
    logic [ADDR_W-1:0]   pc;
    logic                taken;
    logic [ADDR_W-1:0]   target;
    logic [GHR_BITS-1:0] hist;
    logic                is_call;
    logic                is_return;
    logic                mispredict;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_p1, wr_slot1;
  logic [PtrW:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] upd_q, upd_d, mis_q, mis_d;

  logic   in_ready, push0, push1, pop0, pop1;
  logic [1:0] n_push, n_pop, n_mis;
  entry_t in0_e, in1_e, head0, head1;

  always_comb begin
    in0_e = '{pc: bus.in0_pc, taken: bus.in0_taken, target: bus.in0_target, hist: bus.in0_hist,
              is_call: bus.in0_is_call, is_return: bus.in0_is_return,
              mispredict: bus.in0_mispredict};
    in1_e = '{pc: bus.in1_pc, taken: bus.in1_taken, target: bus.in1_target, hist: bus.in1_hist,
              is_call: bus.in1_is_call, is_return: bus.in1_is_return,
              mispredict: bus.in1_mispredict};
  end

  // Readiness uses the start-of-cycle count only; same-cycle pops do not free space.
  assign in_ready  = (count_q <= ReadyMax);
  assign push0     = in_ready & bus.in0_valid;
  assign push1     = in_ready & bus.in1_valid;
  assign wr_slot1  = push0 ? (wr_ptr_q + PtrOne) : wr_ptr_q;

  assign rd_ptr_p1 = rd_ptr_q + PtrOne;
  assign head0     = mem_q[rd_ptr_q];
  assign head1     = mem_q[rd_ptr_p1];
  assign pop0      = ~flush_i & (count_q != '0);
  assign pop1      = ~flush_i & (count_q >= (PtrW + 1)'(2));

  always_comb begin
    n_push     = {1'b0, push0} + {1'b0, push1};
    n_pop      = {1'b0, pop0} + {1'b0, pop1};
    n_mis      = {1'b0, pop0 & head0.mispredict} + {1'b0, pop1 & head1.mispredict};
    count_d    = count_q + (PtrW + 1)'(n_push) - (PtrW + 1)'(n_pop);
    rd_ptr_d   = rd_ptr_q + PtrW'(n_pop);
    wr_ptr_d   = wr_ptr_q + PtrW'(n_push);
    upd_d      = upd_q + CNT_W'(n_pop);
    mis_d      = mis_q + CNT_W'(n_mis);
    overflow_d = overflow_q | (~in_ready & (bus.in0_valid | bus.in1_valid));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      upd_q      <= '0;
      mis_q      <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      upd_q      <= upd_d;
      mis_q      <= mis_d;
    end
  end

  // Storage needs no reset; only the pointers and count define what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (push0) mem_q[wr_ptr_q] <= in0_e;
      if (push1) mem_q[wr_slot1] <= in1_e;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out0_valid     = pop0;
  assign bus.out0_pc        = head0.pc;
  assign bus.out0_taken     = head0.taken;
  assign bus.out0_target    = head0.target;
  assign bus.out0_hist      = head0.hist;
  assign bus.out0_is_call   = head0.is_call;
  assign bus.out0_is_return = head0.is_return;
  assign bus.out1_valid     = pop1;
  assign bus.out1_pc        = head1.pc;
  assign bus.out1_taken     = head1.taken;
  assign bus.out1_target    = head1.target;
  assign bus.out1_hist      = head1.hist;
  assign bus.out1_is_call   = head1.is_call;
  assign bus.out1_is_return = head1.is_return;

  assign occupancy_o     = count_q;
  assign overflow_o      = overflow_q;
  assign upd_count_o     = upd_q;
  assign mispred_count_o = mis_q;

endmodule
